// File: rtl/decode_stage_pipelined.sv
// ID stage and ID/EX pipeline register for the five-stage RV32I core.
// Decodes immediates and control, reads the register file (with WB bypass),
// detects load-use hazards and applies EX flushes.
module decode_stage_pipelined #(
  parameter  int XLEN      = 32,
  parameter  int NREGS     = 32,
  parameter  int HAZARD_EN = 1,
  localparam int RW        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_flush,
  output logic            id_stall,
  output logic            idex_valid,
  output logic [XLEN-1:0] idex_pc,
  output logic [RW-1:0]   idex_rs1,
  output logic [RW-1:0]   idex_rs2,
  output logic [RW-1:0]   idex_rd,
  output logic [XLEN-1:0] idex_imm,
  output logic [XLEN-1:0] idex_rdata1,
  output logic [XLEN-1:0] idex_rdata2,
  output logic            idex_reg_write,
  output logic            idex_mem_read,
  output logic            idex_mem_write,
  output logic            idex_branch,
  output logic            idex_jal,
  output logic            idex_jalr,
  output logic            idex_alu_src_a,
  output logic            idex_alu_src_b,
  output logic [4:0]      idex_alu_op,
  output logic [2:0]      idex_mem_size,
  output logic            idex_illegal
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_R      = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASSB, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
    ALU_BGEU
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jal;
    logic    jalr;
    logic    src_a;
    logic    src_b;
    logic    illegal;
    alu_op_e alu_op;
    logic [2:0] mem_size;
  } ctrl_t;

  function automatic alu_op_e alu_fn(input logic [2:0] f3, input logic f7b5,
                                     input logic is_r);
    case (f3)
      3'd0:    return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return f7b5 ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e br_fn(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_BEQ;
      3'd1:    return ALU_BNE;
      3'd4:    return ALU_BLT;
      3'd5:    return ALU_BGE;
      3'd6:    return ALU_BLTU;
      default: return ALU_BGEU;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [RW-1:0]   rs1, rs2, rd;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  ctrl_t           dec;
  logic            rs1_used, rs2_used;
  logic [XLEN-1:0] rdata1, rdata2;
  logic [XLEN-1:0] regs [NREGS];
  ctrl_t           idex_ctrl;
  logic            bubble;

  assign opcode = if_instr[6:0];
  assign f3     = if_instr[14:12];
  assign rs1    = if_instr[15 +: RW];
  assign rs2    = if_instr[20 +: RW];
  assign rd     = if_instr[7 +: RW];
  assign imm    = XLEN'(signed'(imm32));

  // Instruction decode: immediate, control, ALU op and operand usage
  always_comb begin
    dec      = '0;
    imm32    = '0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_fn(f3, if_instr[30], 1'b1);
        rs2_used      = 1'b1;
      end
      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.src_b     = 1'b1;
        dec.alu_op    = alu_fn(f3, if_instr[30], 1'b0);
        imm32         = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OP_LOAD: begin
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.src_b     = 1'b1;
        dec.mem_size  = f3;
        imm32         = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.src_b     = 1'b1;
        dec.mem_size  = f3;
        rs2_used      = 1'b1;
        imm32         = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      end
      OP_BRANCH: begin
        rs2_used = 1'b1;
        imm32    = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
        if (f3 == 3'd2 || f3 == 3'd3) begin
          dec.illegal = 1'b1;
        end else begin
          dec.branch = 1'b1;
          dec.alu_op = br_fn(f3);
        end
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.src_b     = 1'b1;
        dec.alu_op    = ALU_PASSB;
        rs1_used      = 1'b0;
        imm32         = {if_instr[31:12], 12'b0};
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.src_a     = 1'b1;
        dec.src_b     = 1'b1;
        rs1_used      = 1'b0;
        imm32         = {if_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.jal       = 1'b1;
        dec.reg_write = 1'b1;
        dec.src_a     = 1'b1;
        dec.src_b     = 1'b1;
        rs1_used      = 1'b0;
        imm32         = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                         if_instr[20], if_instr[30:21], 1'b0};
      end
      OP_JALR: begin
        dec.jalr      = 1'b1;
        dec.reg_write = 1'b1;
        dec.src_b     = 1'b1;
        imm32         = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Register file reads with same-cycle writeback bypass; x0 reads as zero
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rs1 != '0) rdata1 = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
    if (rs2 != '0) rdata2 = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
  end

  // Register file write port; x0 is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Load-use hazard: the load in ID/EX writes a register this instruction reads
  always_comb begin
    id_stall = 1'b0;
    if (HAZARD_EN != 0) begin
      id_stall = if_valid && idex_valid && idex_ctrl.mem_read && idex_rd != '0 &&
                 ((idex_rd == rs1 && rs1_used) || (idex_rd == rs2 && rs2_used));
    end
  end

  // Flush and stall both insert a bubble; data fields load regardless
  assign bubble = ex_flush || id_stall || !if_valid;

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_valid  <= 1'b0;
      idex_ctrl   <= '0;
      idex_pc     <= '0;
      idex_rs1    <= '0;
      idex_rs2    <= '0;
      idex_rd     <= '0;
      idex_imm    <= '0;
      idex_rdata1 <= '0;
      idex_rdata2 <= '0;
    end else begin
      idex_valid  <= !bubble;
      idex_ctrl   <= bubble ? ctrl_t'('0) : dec;
      idex_pc     <= if_pc;
      idex_rs1    <= rs1;
      idex_rs2    <= rs2;
      idex_rd     <= rd;
      idex_imm    <= imm;
      idex_rdata1 <= rdata1;
      idex_rdata2 <= rdata2;
    end
  end

  assign idex_reg_write = idex_ctrl.reg_write;
  assign idex_mem_read  = idex_ctrl.mem_read;
  assign idex_mem_write = idex_ctrl.mem_write;
  assign idex_branch    = idex_ctrl.branch;
  assign idex_jal       = idex_ctrl.jal;
  assign idex_jalr      = idex_ctrl.jalr;
  assign idex_alu_src_a = idex_ctrl.src_a;
  assign idex_alu_src_b = idex_ctrl.src_b;
  assign idex_illegal   = idex_ctrl.illegal;
  assign idex_alu_op    = idex_ctrl.alu_op;
  assign idex_mem_size  = idex_ctrl.mem_size;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Scoreboard bench for decode_stage_pipelined: a driver issues directed
// instructions and queues the expected ID/EX contents; a monitor compares.
module tb_decode_stage_pipelined;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_flush;
  logic        id_stall;
  logic        idex_valid;
  logic [31:0] idex_pc;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic [31:0] idex_imm, idex_rdata1, idex_rdata2;
  logic        idex_reg_write, idex_mem_read, idex_mem_write, idex_branch;
  logic        idex_jal, idex_jalr, idex_alu_src_a, idex_alu_src_b, idex_illegal;
  logic [4:0]  idex_alu_op;
  logic [2:0]  idex_mem_size;

  decode_stage_pipelined #(.XLEN(32), .NREGS(32), .HAZARD_EN(1)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_flush(ex_flush), .id_stall(id_stall), .idex_valid(idex_valid),
    .idex_pc(idex_pc), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .idex_rd(idex_rd), .idex_imm(idex_imm), .idex_rdata1(idex_rdata1),
    .idex_rdata2(idex_rdata2), .idex_reg_write(idex_reg_write),
    .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
    .idex_branch(idex_branch), .idex_jal(idex_jal), .idex_jalr(idex_jalr),
    .idex_alu_src_a(idex_alu_src_a), .idex_alu_src_b(idex_alu_src_b),
    .idex_alu_op(idex_alu_op), .idex_mem_size(idex_mem_size),
    .idex_illegal(idex_illegal)
  );

  always #5 clk = ~clk;

  // control bit order: reg_write mem_read mem_write branch jal jalr src_a src_b illegal
  localparam logic [8:0] C_RW = 9'h100, C_MR = 9'h080, C_MW = 9'h040,
                         C_BR = 9'h020, C_SB = 9'h002, C_ILL = 9'h001;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic        valid;
    logic        chk_ctrl;
    logic [8:0]  ctrl;
    logic [4:0]  alu;
    logic [2:0]  ms;
    logic [31:0] imm;
    logic        chk_data;
    logic [31:0] r1, r2;
    logic [4:0]  rd;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [31:0] pc = 32'h1000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic cc, input logic [8:0] c,
                              input logic [4:0] a, input logic [2:0] m,
                              input logic [31:0] im, input logic cd,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [4:0] rd);
    exp_t e;
    e.valid = v; e.chk_ctrl = cc; e.ctrl = c; e.alu = a; e.ms = m; e.imm = im;
    e.chk_data = cd; e.r1 = r1; e.r2 = r2; e.rd = rd; e.pc = '0;
    return e;
  endfunction

  function automatic exp_t bub();
    return mk(1'b0, 1'b1, '0, '0, '0, '0, 1'b0, '0, '0, '0);
  endfunction

  function automatic exp_t idle();
    return mk(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0, '0, '0);
  endfunction

  function automatic logic [8:0] dut_ctrl();
    return {idex_reg_write, idex_mem_read, idex_mem_write, idex_branch, idex_jal,
            idex_jalr, idex_alu_src_a, idex_alu_src_b, idex_illegal};
  endfunction

  // present one IF/ID slot, check the combinational stall, queue the expectation
  task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic st, input exp_t e);
    if_valid = v; if_instr = ins; ex_flush = fl;
    wb_en = we; wb_rd = wr; wb_data = wd; if_pc = pc;
    #1 chk("id_stall", {31'b0, id_stall}, {31'b0, st});
    e.pc = pc;
    @(posedge clk);
    sb.push_back(e);
    #1;
    if (!st) pc += 4;
  endtask

  // monitor: compare ID/EX against the oldest expectation once per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("idex_valid", {31'b0, idex_valid}, {31'b0, e.valid});
        if (e.chk_ctrl) chk("idex_ctrl", {23'b0, dut_ctrl()}, {23'b0, e.ctrl});
        if (e.valid) begin
          chk("idex_alu_op", {27'b0, idex_alu_op}, {27'b0, e.alu});
          chk("idex_mem_size", {29'b0, idex_mem_size}, {29'b0, e.ms});
          chk("idex_imm", idex_imm, e.imm);
          chk("idex_rd", {27'b0, idex_rd}, {27'b0, e.rd});
          chk("idex_pc", idex_pc, e.pc);
        end
        if (e.chk_data) begin
          chk("idex_rdata1", idex_rdata1, e.r1);
          chk("idex_rdata2", idex_rdata2, e.r2);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = NOP;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_flush = 1'b0;
    #3;
    chk("rst_valid", {31'b0, idex_valid}, 32'd0);
    chk("rst_ctrl", {23'b0, dut_ctrl()}, 32'd0);
    chk("rst_imm", idex_imm, 32'd0);
    #9 reset = 1'b1;
    @(posedge clk); #1;

    // preload x2, x3, x5, x7
    step(0, NOP, 0, 1, 5'd2, 32'h100, 0, idle());
    step(0, NOP, 0, 1, 5'd3, 32'h33,  0, idle());
    step(0, NOP, 0, 1, 5'd5, 32'h55,  0, idle());
    step(0, NOP, 0, 1, 5'd7, 32'h777, 0, idle());

    // addi x1,x0,-5
    step(1, 32'hFFB00093, 0, 0, 0, 0, 0,
         mk(1, 1, C_RW | C_SB, 5'd0, 3'd0, 32'hFFFFFFFB, 1, 32'h0, 32'h0, 5'd1));
    // lw x5,0(x2) ; add x6,x5,x3 -> one stall, one bubble, then add
    step(1, 32'h00012283, 0, 0, 0, 0, 0,
         mk(1, 1, C_RW | C_MR | C_SB, 5'd0, 3'd2, 32'h0, 1, 32'h100, 32'h0, 5'd5));
    step(1, 32'h00328333, 0, 0, 0, 0, 1, bub());
    step(1, 32'h00328333, 0, 0, 0, 0, 0,
         mk(1, 1, C_RW, 5'd0, 3'd0, 32'h0, 1, 32'h55, 32'h33, 5'd6));
    // add x8,x7,x7 with writeback to x7 in the same cycle
    step(1, 32'h00738433, 0, 1, 5'd7, 32'h1234, 0,
         mk(1, 1, C_RW, 5'd0, 3'd0, 32'h0, 1, 32'h1234, 32'h1234, 5'd8));
    // beq -8, first flushed, then taken normally
    step(1, 32'hFE000CE3, 1, 0, 0, 0, 0, bub());
    step(1, 32'hFE000CE3, 0, 0, 0, 0, 0,
         mk(1, 1, C_BR, 5'd11, 3'd0, 32'hFFFFFFF8, 1, 32'h0, 32'h0, 5'd25));
    // write to x0 is ignored, bypass never applies to x0
    step(1, 32'h000004B3, 0, 1, 5'd0, 32'hDEAD, 0,
         mk(1, 1, C_RW, 5'd0, 3'd0, 32'h0, 1, 32'h0, 32'h0, 5'd9));
    step(1, 32'h000004B3, 0, 0, 0, 0, 0,
         mk(1, 1, C_RW, 5'd0, 3'd0, 32'h0, 1, 32'h0, 32'h0, 5'd9));
    // unsupported opcode 0x7F
    step(1, 32'h0000007F, 0, 0, 0, 0, 0,
         mk(1, 1, C_ILL, 5'd0, 3'd0, 32'h0, 0, 32'h0, 32'h0, 5'd0));
    // lw x5 then lui whose rs1 field is 5 but unused -> no stall
    step(1, 32'h00012283, 0, 0, 0, 0, 0,
         mk(1, 1, C_RW | C_MR | C_SB, 5'd0, 3'd2, 32'h0, 1, 32'h100, 32'h0, 5'd5));
    step(1, 32'h00028537, 0, 0, 0, 0, 0,
         mk(1, 1, C_RW | C_SB, 5'd10, 3'd0, 32'h00028000, 0, 32'h0, 32'h0, 5'd10));
    // sw x3,4(x2) ; sub x11,x2,x3 ; srai x12,x2,3
    step(1, 32'h00312223, 0, 0, 0, 0, 0,
         mk(1, 1, C_MW | C_SB, 5'd0, 3'd2, 32'h4, 1, 32'h100, 32'h33, 5'd4));
    step(1, 32'h403105B3, 0, 0, 0, 0, 0,
         mk(1, 1, C_RW, 5'd1, 3'd0, 32'h0, 1, 32'h100, 32'h33, 5'd11));
    step(1, 32'h40315613, 0, 0, 0, 0, 0,
         mk(1, 1, C_RW | C_SB, 5'd7, 3'd0, 32'h403, 1, 32'h100, 32'h33, 5'd12));
    // flush arriving during a load-use stall: bubble, then IF redirects
    step(1, 32'h00012283, 0, 0, 0, 0, 0,
         mk(1, 1, C_RW | C_MR | C_SB, 5'd0, 3'd2, 32'h0, 1, 32'h100, 32'h0, 5'd5));
    step(1, 32'h00328333, 1, 0, 0, 0, 1, bub());
    step(1, 32'hFFB00093, 0, 0, 0, 0, 0,
         mk(1, 1, C_RW | C_SB, 5'd0, 3'd0, 32'hFFFFFFFB, 1, 32'h0, 32'h0, 5'd1));
    // x7 kept the bypassed write
    step(1, 32'h00738433, 0, 0, 0, 0, 0,
         mk(1, 1, C_RW, 5'd0, 3'd0, 32'h0, 1, 32'h1234, 32'h1234, 5'd8));
    // load to x0 never stalls a consumer
    step(1, 32'h00012003, 0, 0, 0, 0, 0,
         mk(1, 1, C_RW | C_MR | C_SB, 5'd0, 3'd2, 32'h0, 1, 32'h100, 32'h0, 5'd0));
    step(1, 32'h00300333, 0, 0, 0, 0, 0,
         mk(1, 1, C_RW, 5'd0, 3'd0, 32'h0, 1, 32'h0, 32'h33, 5'd6));

    // asynchronous reset mid-stream with a valid instruction in ID/EX
    if_valid = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("async_valid", {31'b0, idex_valid}, 32'd0);
    chk("async_ctrl", {23'b0, dut_ctrl()}, 32'd0);
    chk("async_rdata2", idex_rdata2, 32'd0);
    chk("async_rd", {27'b0, idex_rd}, 32'd0);
    chk("async_pc", idex_pc, 32'd0);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    // register file was cleared by reset
    step(1, 32'h00738433, 0, 0, 0, 0, 0,
         mk(1, 1, C_RW, 5'd0, 3'd0, 32'h0, 1, 32'h0, 32'h0, 5'd8));
    if_valid = 1'b0;

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1 chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
